// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
// Byte-stream command decoder driving a single-word AHB-lite master.
// A command is an opcode byte followed by a 4-byte address (MSB first) and,
// for writes, a 4-byte data word (MSB first). Each command issues one NONSEQ
// word transfer and returns a response on the tx byte stream:
//   'W' (0x57) write -> 0x06
//   'R' (0x52) read  -> 4 bytes of read data, MSB first
//   other opcode     -> 0x15, no bus activity
//
// Ports
//   clk, RSTn                     clock (HCLK) and async active-low reset
//   rx_data/rx_valid/rx_ready     command byte stream in
//   tx_data/tx_valid/tx_ready     response byte stream out
//   HADDR..HWDATA                 AHB-lite master outputs
//   HRDATA, HREADY, HRESP         AHB-lite master inputs
//   busy                          high whenever a command is in progress
//
// Build option
//   AHB_CMD_MASTER_ERR_EN  when defined, HRESP=1 on the completing data cycle
//                          turns the response into the single byte 0x15.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | waiting for an opcode byte
// S_GET_ADDR | shifting in 4 address bytes
// S_GET_DATA | shifting in 4 write data bytes
// S_AHB_ADDR | NONSEQ address phase, held until HREADY
// S_AHB_DATA | data phase, waits while HREADY=0
// S_RESP     | presenting response bytes on tx
module ahb_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_AHB_ADDR, S_AHB_DATA, S_RESP
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;        // bytes remaining minus one in a field
  logic [1:0]  left_q, left_d;      // response bytes remaining after current
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;    // read bytes still to send, left-aligned
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rst_done_q;          // keeps rx_ready low until first edge after reset

  logic rx_fire, tx_fire;

`ifndef AHB_CMD_MASTER_ERR_EN
  logic unused_hresp;
  assign unused_hresp = HRESP;
`endif

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

  // State register
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= 2'd0;
      left_q     <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      tx_data_q  <= 8'h00;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            state_d = S_GET_ADDR;
            is_wr_d = (rx_data == OP_WRITE);
            cnt_d   = 2'd3;
          end else begin
            state_d   = S_RESP;
            tx_data_d = RSP_NAK;
            left_d    = 2'd0;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], rx_data};
          if (cnt_q == 2'd0) begin
            state_d = is_wr_q ? S_GET_DATA : S_AHB_ADDR;
            cnt_d   = 2'd3;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_fire) begin
          wdata_d = {wdata_q[23:0], rx_data};
          if (cnt_q == 2'd0) begin
            state_d = S_AHB_ADDR;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_AHB_ADDR: begin
        if (HREADY) state_d = S_AHB_DATA;
      end
      S_AHB_DATA: begin
        if (HREADY) begin
          state_d = S_RESP;
          if (is_wr_q) begin
            tx_data_d = RSP_ACK;
            left_d    = 2'd0;
          end else begin
            tx_data_d = HRDATA[31:24];
            rdata_d   = {HRDATA[23:0], 8'h00};
            left_d    = 2'd3;
          end
`ifdef AHB_CMD_MASTER_ERR_EN
          if (HRESP) begin
            tx_data_d = RSP_NAK;
            left_d    = 2'd0;
          end
`endif
        end
      end
      S_RESP: begin
        if (tx_fire) begin
          if (left_q == 2'd0) begin
            state_d   = S_IDLE;
            tx_data_d = 8'h00;
          end else begin
            tx_data_d = rdata_q[31:24];
            rdata_d   = {rdata_q[23:0], 8'h00};
            left_d    = left_q - 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = (state_q != S_IDLE);
    HTRANS   = 2'b00;
    HWRITE   = 1'b0;
    case (state_q)
      S_IDLE, S_GET_ADDR, S_GET_DATA: rx_ready = rst_done_q;
      S_AHB_ADDR: begin
        HTRANS = 2'b10;
        HWRITE = is_wr_q;
      end
      S_RESP: tx_valid = 1'b1;
      default: ;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign HADDR     = {addr_q[31:2], 2'b00};
  assign HWDATA    = wdata_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule
